// File: rtl/uart_pkg.sv
// uart_pkg: shared register map, bit indices, state enums and parity helper for the FIFO UART
package uart_pkg;
   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_RXDATA = 4'h4;
   localparam logic [3:0] OFF_STATUS = 4'h8;
   localparam logic [3:0] OFF_CTRL   = 4'hC;
   localparam int ST_TX_FULL      = 0;
   localparam int ST_TX_IDLE      = 1;
   localparam int ST_RX_EMPTY     = 2;
   localparam int ST_RX_FULL      = 3;
   localparam int ST_RX_OVERRUN   = 4;
   localparam int ST_PARITY_ERR   = 5;
   localparam int ST_FRAMING_ERR  = 6;
   localparam int ST_TX_OVERFLOW  = 7;
   localparam int ST_RX_COUNT_LSB = 8;
   localparam int CTRL_RX_IRQ_EN  = 16;
   localparam int CTRL_ERR_IRQ_EN = 17;
   localparam logic [15:0] MIN_DIVISOR = 16'd16;
   typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_mode_e;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
   function automatic logic parity_bit(input logic [7:0] d, input parity_mode_e m);
      return (m == PAR_ODD) ? ~^d : ^d;
   endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO, WIDTH bits x DEPTH entries (DEPTH a power of two)
// Ports: clock_i/reset_n_i (async active-low), push_i/wdata_i write side,
//        pop_i/rdata_o read side (rdata_o shows the head), full_o, empty_o, count_o (0..DEPTH).
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clock_i,
   input  logic                     reset_n_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push, do_pop;
   assign full_o  = count_q == (AW+1)'(DEPTH);
   assign empty_o = count_q == '0;
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];
   assign do_pop  = pop_i & ~empty_o;
   // a pop frees the slot a same-cycle push needs, so a full FIFO accepts both
   assign do_push = push_i & (~full_o | do_pop);
   always_ff @(posedge clock_i or negedge reset_n_i)
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   always_ff @(posedge clock_i)
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
endmodule

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: memory-mapped UART with TX/RX FIFOs, runtime divisor, parity, sticky errors, level IRQ
// Ports: clock, reset_n (async active-low); rw_address/read_request/read_data/read_response and
//        write_data/write_request/write_response form the 1-cycle IO bus; uart_rx (async serial in),
//        uart_tx (serial out, idles high), uart_irq (registered level interrupt).
module uart_fifo_ctrl
   import uart_pkg::*;
#(
   parameter int          CLOCK_FREQUENCY = 50000000,
   parameter int          UART_BAUD_RATE  = 9600,
   parameter logic [31:0] BASE_ADDRESS    = 32'h80000000,
   parameter int          FIFO_DEPTH      = 16,
   parameter int          PARITY_MODE     = 0,
   parameter int          STOP_BITS       = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] rw_address,
   output logic [31:0] read_data,
   input  logic        read_request,
   output logic        read_response,
   input  logic [31:0] write_data,
   input  logic        write_request,
   output logic        write_response,
   input  logic        uart_rx,
   output logic        uart_tx,
   output logic        uart_irq
);
   localparam int           CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0]  DIV_RESET = 16'(CLOCK_FREQUENCY / UART_BAUD_RATE);
   localparam parity_mode_e PMODE     = parity_mode_e'(PARITY_MODE);
   logic [31:0] read_data_q, rd_val, status, ctrl;
   logic        read_resp_q, write_resp_q, irq_q, irq_d;
   logic [15:0] div_q, div_d;
   logic        rx_en_q, err_en_q;
   logic [3:0]  sticky_q, sticky_d, sticky_set, sticky_clr;
   logic        hit, wr_tx, wr_status, wr_ctrl, rd_rx;
   logic [7:0]  tx_rdata, rx_rdata;
   logic        tx_full, tx_empty, rx_full, rx_empty, tx_idle;
   logic [CW-1:0] tx_count, rx_count;
   logic        unused_ok;
   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        tx_par_q, tx_par_d, tx_stop_q, tx_stop_d;
   logic        tx_tick, tx_last_stop, tx_pop;
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d;
   logic        rx_perr_q, rx_perr_d;
   logic        rx_s1_q, rx_s2_q, rx_prev_q;
   logic        rx_tick, rx_fall, rx_stop_sample, rx_good;
   assign unused_ok = ^{write_data[31:18], tx_count};
   assign hit       = rw_address[31:4] == BASE_ADDRESS[31:4];
   assign wr_tx     = write_request & hit & (rw_address[3:0] == OFF_TXDATA);
   assign wr_status = write_request & hit & (rw_address[3:0] == OFF_STATUS);
   assign wr_ctrl   = write_request & hit & (rw_address[3:0] == OFF_CTRL);
   assign rd_rx     = read_request & hit & (rw_address[3:0] == OFF_RXDATA);
   assign tx_idle   = tx_empty & (tx_state_q == TX_IDLE);
   assign status    = {15'b0, 9'(rx_count), sticky_q, rx_full, rx_empty, tx_idle, tx_full};
   assign ctrl      = {14'b0, err_en_q, rx_en_q, div_q};
   assign rd_val    = !(read_request && hit) ? '0 :
                      rw_address[3:0] == OFF_TXDATA ? {31'b0, ~tx_full} :
                      rw_address[3:0] == OFF_RXDATA ? {24'b0, rx_empty ? 8'h00 : rx_rdata} :
                      rw_address[3:0] == OFF_STATUS ? status :
                      rw_address[3:0] == OFF_CTRL   ? ctrl : '0;
   assign div_d     = !wr_ctrl ? div_q : write_data[15:0] < MIN_DIVISOR ? MIN_DIVISOR : write_data[15:0];
   // flag order matches STATUS[7:4]: tx_overflow, framing_err, parity_err, rx_overrun
   assign sticky_set = {wr_tx & tx_full & ~tx_pop,
                        rx_stop_sample & ~rx_s2_q,
                        rx_stop_sample & rx_perr_q,
                        rx_good & rx_full & ~rd_rx};
   assign sticky_clr = wr_status ? write_data[ST_TX_OVERFLOW:ST_RX_OVERRUN] : 4'b0;
   assign sticky_d   = (sticky_q & ~sticky_clr) | sticky_set;
   assign irq_d      = (rx_en_q & ~rx_empty) | (err_en_q & |sticky_q);
   assign read_data      = read_data_q;
   assign read_response  = read_resp_q;
   assign write_response = write_resp_q;
   assign uart_irq       = irq_q;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         read_data_q  <= '0;
         read_resp_q  <= 1'b0;
         write_resp_q <= 1'b0;
         irq_q        <= 1'b0;
         div_q        <= DIV_RESET;
         rx_en_q      <= 1'b0;
         err_en_q     <= 1'b0;
         sticky_q     <= '0;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
      end else begin
         read_data_q  <= rd_val;
         read_resp_q  <= read_request;
         write_resp_q <= write_request;
         irq_q        <= irq_d;
         div_q        <= div_d;
         rx_en_q      <= wr_ctrl ? write_data[CTRL_RX_IRQ_EN] : rx_en_q;
         err_en_q     <= wr_ctrl ? write_data[CTRL_ERR_IRQ_EN] : err_en_q;
         sticky_q     <= sticky_d;
         rx_s1_q      <= uart_rx;
         rx_s2_q      <= rx_s1_q;
         rx_prev_q    <= rx_s2_q;
      end
   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clock_i(clock), .reset_n_i(reset_n), .push_i(wr_tx), .pop_i(tx_pop),
      .wdata_i(write_data[7:0]), .rdata_o(tx_rdata), .full_o(tx_full), .empty_o(tx_empty),
      .count_o(tx_count));
   uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clock_i(clock), .reset_n_i(reset_n), .push_i(rx_good), .pop_i(rd_rx),
      .wdata_i(rx_sh_q), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty),
      .count_o(rx_count));
   assign tx_tick      = tx_cnt_q == '0;
   assign tx_last_stop = (STOP_BITS == 1) | tx_stop_q;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_par_q   <= 1'b0;
         tx_stop_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_par_q   <= tx_par_d;
         tx_stop_q  <= tx_stop_d;
      end
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = (tx_tick || tx_state_q == TX_IDLE) ? div_q - 16'd1 : tx_cnt_q - 16'd1;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_par_d   = tx_par_q;
      tx_stop_d  = tx_stop_q;
      // popping straight out of the last stop bit is what keeps back-to-back frames gapless
      if (tx_pop) begin
         tx_state_d = TX_START;
         tx_cnt_d   = div_q - 16'd1;
         tx_sh_d    = tx_rdata;
         tx_par_d   = parity_bit(tx_rdata, PMODE);
      end else if (tx_tick) begin
         unique case (tx_state_q)
            TX_START: begin
               tx_state_d = TX_DATA;
               tx_bit_d   = '0;
            end
            TX_DATA: begin
               tx_sh_d   = tx_sh_q >> 1;
               tx_bit_d  = tx_bit_q + 3'd1;
               tx_stop_d = 1'b0;
               if (tx_bit_q == 3'd7) tx_state_d = (PMODE != PAR_NONE) ? TX_PARITY : TX_STOP;
            end
            TX_PARITY: tx_state_d = TX_STOP;
            TX_STOP: begin
               tx_stop_d  = 1'b1;
               tx_state_d = tx_last_stop ? TX_IDLE : TX_STOP;
            end
            default: tx_state_d = TX_IDLE;
         endcase
      end
   end
   always_comb begin
      tx_pop  = ~tx_empty & (tx_state_q == TX_IDLE || (tx_state_q == TX_STOP && tx_tick && tx_last_stop));
      uart_tx = tx_state_q == TX_START  ? 1'b0 :
                tx_state_q == TX_DATA   ? tx_sh_q[0] :
                tx_state_q == TX_PARITY ? tx_par_q : 1'b1;
   end
   assign rx_tick = rx_cnt_q == '0;
   assign rx_fall = rx_prev_q & ~rx_s2_q;
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_perr_q  <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_perr_q  <= rx_perr_d;
      end
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_tick ? div_q - 16'd1 : rx_cnt_q - 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_perr_d  = rx_perr_q;
      unique case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = {1'b0, div_q[15:1]} - 16'd1;
            if (rx_fall) rx_state_d = RX_START;
         end
         RX_START: if (rx_tick) begin
            rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            rx_bit_d   = '0;
            rx_perr_d  = 1'b0;
         end
         RX_DATA: if (rx_tick) begin
            rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
            rx_bit_d = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = (PMODE != PAR_NONE) ? RX_PARITY : RX_STOP;
         end
         RX_PARITY: if (rx_tick) begin
            rx_perr_d  = rx_s2_q != parity_bit(rx_sh_q, PMODE);
            rx_state_d = RX_STOP;
         end
         RX_STOP: if (rx_tick) rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
   end
   always_comb begin
      rx_stop_sample = (rx_state_q == RX_STOP) & rx_tick;
      rx_good        = rx_stop_sample & rx_s2_q & ~rx_perr_q;
   end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: register-table checks plus read/TX scoreboards for uart_fifo_ctrl (even parity, depth 16)
module tb_uart_fifo_ctrl;
   localparam logic [31:0] B = 32'h8000_0000;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic [31:0] rw_address = '0;
   logic [31:0] read_data;
   logic        read_request = 1'b0;
   logic        read_response;
   logic [31:0] write_data = '0;
   logic        write_request = 1'b0;
   logic        write_response;
   logic        uart_rx = 1'b1;
   logic        uart_tx;
   logic        uart_irq;
   int          checks = 0;
   int          failures = 0;
   int          tb_div = 16;
   int          rd_n = 0;
   bit          tx_mon_en = 1'b1;
   logic [31:0] sb_q[$];
   int          tag_q[$];
   logic [7:0]  tx_exp_q[$];
   logic [7:0]  rx_model[$];
   typedef struct {bit wr; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp;} vec_t;
   vec_t vecs[15];
   always #5 clock = ~clock;
   uart_fifo_ctrl #(.PARITY_MODE(1), .FIFO_DEPTH(16), .STOP_BITS(1)) u_dut (
      .clock(clock), .reset_n(reset_n), .rw_address(rw_address), .read_data(read_data),
      .read_request(read_request), .read_response(read_response), .write_data(write_data),
      .write_request(write_request), .write_response(write_response), .uart_rx(uart_rx),
      .uart_tx(uart_tx), .uart_irq(uart_irq));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [10:0] frame(input logic [7:0] d);
      return {1'b1, ^d, d, 1'b0};
   endfunction
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(posedge clock); #1;
      rw_address = a; write_data = d; write_request = 1'b1;
      @(posedge clock); #1;
      write_request = 1'b0;
      @(negedge clock);
      chk("write_response", {31'b0, write_response}, 32'd1);
   endtask
   task automatic bus_read(input logic [31:0] a, input logic [31:0] e);
      @(posedge clock); #1;
      rw_address = a; read_request = 1'b1;
      sb_q.push_back(e);
      tag_q.push_back(rd_n++);
      @(posedge clock); #1;
      read_request = 1'b0;
      @(negedge clock);
   endtask
   task automatic read_rx();
      bus_read(B + 32'h4, rx_model.size() > 0 ? {24'b0, rx_model.pop_front()} : 32'h0);
   endtask
   task automatic send_rx(input logic [7:0] d, input bit bad_par, input bit bad_stop);
      logic [10:0] f;
      f = frame(d);
      f[9]  = f[9] ^ bad_par;
      f[10] = ~bad_stop;
      @(posedge clock); #1;
      for (int k = 0; k < 11; k++) begin
         uart_rx = f[k];
         repeat (tb_div) @(posedge clock);
         #1;
      end
      uart_rx = 1'b1;
      if (bad_stop) begin
         repeat (tb_div) @(posedge clock);
         #1;
      end
   endtask
   task automatic send_good(input logic [7:0] d);
      send_rx(d, 1'b0, 1'b0);
      if (rx_model.size() < 16) rx_model.push_back(d);
   endtask
   task automatic tx_drain();
      for (int i = 0; i < 6000 && tx_exp_q.size() > 0; i++) @(negedge clock);
      chk("tx drain", tx_exp_q.size(), 0);
      repeat (16) @(negedge clock);
   endtask
   task automatic irq_is(input string name, input logic e);
      repeat (2) @(negedge clock);
      chk(name, {31'b0, uart_irq}, {31'b0, e});
   endtask
   always @(negedge clock)
      if (read_response) begin
         if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL read unexpected: got %h expected no response", read_data);
         end else chk($sformatf("read#%0d", tag_q.pop_front()), read_data, sb_q.pop_front());
      end
   initial begin
      logic [10:0] got;
      forever begin
         @(negedge clock);
         if (tx_mon_en && reset_n && uart_tx === 1'b0) begin
            repeat (tb_div / 2 - 1) @(negedge clock);
            for (int k = 0; k < 11; k++) begin
               got[k] = uart_tx;
               if (k < 10) repeat (tb_div) @(negedge clock);
            end
            if (tx_exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL tx frame: got %h expected none", got);
            end else chk("tx frame", {21'b0, got}, {21'b0, frame(tx_exp_q.pop_front())});
         end
      end
   end
   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      vecs[0]  = '{0, B + 32'hC,  32'h0,         32'h0000_1458};
      vecs[1]  = '{0, B + 32'h8,  32'h0,         32'h0000_0006};
      vecs[2]  = '{0, B + 32'h0,  32'h0,         32'h0000_0001};
      vecs[3]  = '{0, B + 32'h4,  32'h0,         32'h0000_0000};
      vecs[4]  = '{0, B + 32'h10, 32'h0,         32'h0000_0000};
      vecs[5]  = '{1, B + 32'hC,  32'h0000_0005, 32'h0};
      vecs[6]  = '{0, B + 32'hC,  32'h0,         32'h0000_0010};
      vecs[7]  = '{1, B + 32'hC,  32'h0003_FFFF, 32'h0};
      vecs[8]  = '{0, B + 32'hC,  32'h0,         32'h0003_FFFF};
      vecs[9]  = '{1, B + 32'h8,  32'h0000_00F0, 32'h0};
      vecs[10] = '{0, B + 32'h8,  32'h0,         32'h0000_0006};
      vecs[11] = '{1, B + 32'hC,  32'h0000_0010, 32'h0};
      vecs[12] = '{0, B + 32'hC,  32'h0,         32'h0000_0010};
      vecs[13] = '{1, B + 32'hC,  32'h0000_000F, 32'h0};
      vecs[14] = '{0, B + 32'hC,  32'h0,         32'h0000_0010};
      repeat (3) @(posedge clock);
      #1;
      chk("reset uart_tx", {31'b0, uart_tx}, 32'd1);
      chk("reset read_response", {31'b0, read_response}, 32'd0);
      chk("reset write_response", {31'b0, write_response}, 32'd0);
      chk("reset uart_irq", {31'b0, uart_irq}, 32'd0);
      chk("reset read_data", read_data, 32'd0);
      reset_n = 1'b1;
      for (int i = 0; i < 15; i++)
         if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
         else bus_read(vecs[i].addr, vecs[i].exp);
      repeat (2) @(negedge clock);
      chk("read_data idle", read_data, 32'd0);
      tx_exp_q.push_back(8'h55);
      bus_write(B, 32'h55);
      tx_drain();
      bus_read(B + 32'h8, 32'h0000_0006);
      tx_exp_q.push_back(8'h0F);
      bus_write(B, 32'h0F);
      for (int i = 0; i < 50 && uart_tx !== 1'b0; i++) @(negedge clock);
      chk("tx started", {31'b0, uart_tx}, 32'd0);
      for (int i = 0; i < 17; i++) begin
         if (i < 16) tx_exp_q.push_back(8'(i * 37 + 5));
         bus_write(B, 32'(8'(i * 37 + 5)));
      end
      bus_read(B + 32'h8, 32'h0000_0085);
      bus_read(B, 32'h0);
      bus_write(B + 32'h8, 32'h80);
      bus_read(B + 32'h8, 32'h0000_0005);
      tx_drain();
      bus_read(B + 32'h8, 32'h0000_0006);
      send_good(8'hA3);
      bus_read(B + 32'h8, 32'h0000_0102);
      read_rx();
      bus_read(B + 32'h8, 32'h0000_0006);
      read_rx();
      send_rx(8'h3C, 1'b1, 1'b0);
      bus_read(B + 32'h8, 32'h0000_0026);
      send_rx(8'h5A, 1'b0, 1'b1);
      bus_read(B + 32'h8, 32'h0000_0066);
      bus_write(B + 32'hC, 32'h0002_0010);
      irq_is("err irq set", 1'b1);
      read_rx();
      bus_write(B + 32'h8, 32'h60);
      irq_is("err irq cleared", 1'b0);
      bus_read(B + 32'h8, 32'h0000_0006);
      bus_write(B + 32'hC, 32'h0001_0010);
      irq_is("rx irq idle", 1'b0);
      for (int i = 0; i < 17; i++) send_good(8'(i * 53 + 7));
      bus_read(B + 32'h8, 32'h0000_101A);
      irq_is("rx irq set", 1'b1);
      for (int i = 0; i < 17; i++) read_rx();
      bus_write(B + 32'h8, 32'h10);
      bus_read(B + 32'h8, 32'h0000_0006);
      irq_is("rx irq cleared", 1'b0);
      bus_write(B + 32'hC, 32'h20);
      tb_div = 32;
      @(posedge clock); #1;
      uart_rx = 1'b0;
      repeat (4) @(posedge clock);
      #1;
      uart_rx = 1'b1;
      repeat (80) @(posedge clock);
      bus_read(B + 32'h8, 32'h0000_0006);
      tx_mon_en = 1'b0;
      bus_write(B, 32'h00);
      for (int i = 0; i < 50 && uart_tx !== 1'b0; i++) @(negedge clock);
      repeat (20) @(posedge clock);
      #2;
      chk("tx low before reset", {31'b0, uart_tx}, 32'd0);
      reset_n = 1'b0;
      #1;
      chk("tx async reset", {31'b0, uart_tx}, 32'd1);
      @(posedge clock); #1;
      reset_n = 1'b1;
      bus_read(B + 32'hC, 32'h0000_1458);
      bus_read(B + 32'h8, 32'h0000_0006);
      repeat (4) @(negedge clock);
      chk("read scoreboard empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
